// File: rtl/vram_pkg.sv
// Shared types and constants for the VGA frame RAM write path.
package vram_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam int VRAM_NUM_REQ   = 4;
    localparam int VRAM_ADDR_W    = 16;
    localparam int VRAM_DATA_W    = 8;
    localparam int VRAM_IDLE_ADDR = 65535;
    localparam int VGA_H_LAST     = 799;
    localparam int VGA_V_LAST     = 524;
    localparam int VRAM_TIMEOUT   = 4095;

    // Layering order of the render engines
    localparam int ENG_MAZE    = 0;
    localparam int ENG_SCORE   = 1;
    localparam int ENG_LIVES   = 2;
    localparam int ENG_SPRITES = 3;

    // Base addresses of the score and lives overlays in the frame RAM
    localparam logic [15:0] SCORE_BASE_ADDR = 16'd63360;
    localparam logic [15:0] LIVES_BASE_ADDR = 16'd63808;

endpackage

// File: rtl/vram_wr_mux.sv
// Registered N:1 select of engine write address/data onto the frame RAM
// write port. The port parks on the discard address whenever no write is
// issued; the pixel value simply holds.
module vram_wr_mux #(
    parameter int              NUM_REQ   = 4,
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 8,
    parameter int              IDX_W     = 2,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          sel_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         data_o
);

    localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NUM_REQ - 1);

    logic [ADDR_W-1:0] addr_arr_s [NUM_REQ];
    logic [DATA_W-1:0] data_arr_s [NUM_REQ];
    logic [IDX_W-1:0]  sel_s;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;

    for (genvar gk = 0; gk < NUM_REQ; gk++) begin : g_slice
        assign addr_arr_s[gk] = req_addr_i[gk*ADDR_W +: ADDR_W];
        assign data_arr_s[gk] = req_data_i[gk*DATA_W +: DATA_W];
    end

    // Clamp the select only when the index width can encode unused engines
    if ((2 ** IDX_W) > NUM_REQ) begin : g_clamp
        // Keep the select inside the populated engine range
        always_comb begin
            if (sel_i > SEL_LAST) begin
                sel_s = SEL_LAST;
            end else begin
                sel_s = sel_i;
            end
        end
    end else begin : g_pass
        assign sel_s = sel_i;
    end

    // Next write-port value: selected engine on a write, discard address otherwise
    always_comb begin
        addr_d = IDLE_ADDR;
        data_d = data_q;
        if (wr_en_i) begin
            addr_d = addr_arr_s[sel_s];
            data_d = data_arr_s[sel_s];
        end else begin
            addr_d = IDLE_ADDR;
            data_d = data_q;
        end
    end

    // Write-port output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= IDLE_ADDR;
            data_q <= {DATA_W{1'b0}};
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/vram_frame_sched.sv
// Per-frame write scheduler for the ping-pong VGA frame RAM. Each frame the
// render engines take the single write port in fixed layering order; a phase
// ends on the engine's last write or after too long without a request. The
// buffer swap point restarts the sequence and guards against stray writes.
module vram_frame_sched
    import vram_pkg::*;
#(
    parameter int NUM_REQ   = VRAM_NUM_REQ,
    parameter int ADDR_W    = VRAM_ADDR_W,
    parameter int DATA_W    = VRAM_DATA_W,
    parameter int IDLE_ADDR = VRAM_IDLE_ADDR,
    parameter int H_LAST    = VGA_H_LAST,
    parameter int V_LAST    = VGA_V_LAST,
    parameter int TIMEOUT   = VRAM_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                vga_h,
    input  logic [9:0]                vga_v,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        phase_start,
    output logic [ADDR_W-1:0]         addr_write,
    output logic [DATA_W-1:0]         data_write,
    output logic                      back_buf,
    output logic                      frame_done,
    output logic                      overrun,
    output logic [NUM_REQ-1:0]        skipped
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [9:0]        H_LAST_V  = 10'(H_LAST);
    localparam logic [9:0]        V_LAST_V  = 10'(V_LAST);
    localparam logic [ADDR_W-1:0] IDLE_A    = ADDR_W'(IDLE_ADDR);

    sched_state_t        state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic [NUM_REQ-1:0]  skipped_q, skipped_d;
    logic                overrun_q, overrun_d;
    logic                back_buf_q, back_buf_d;

    logic                swap_now_s;
    logic                cur_req_s;
    logic                cur_last_s;
    logic                wr_en_s;
    logic                phase_end_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [NUM_REQ-1:0]  phase_start_s;

    assign swap_now_s = (vga_h == H_LAST_V) && (vga_v == V_LAST_V);
    assign cur_req_s  = req[idx_q];
    assign cur_last_s = req_last[idx_q];

    // Frame sequencer next state; the swap point overrides any phase activity
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        skipped_d   = skipped_q;
        overrun_d   = 1'b0;
        wr_en_s     = 1'b0;
        phase_end_s = 1'b0;
        if (swap_now_s) begin
            skipped_d = {NUM_REQ{1'b0}};
            idle_d    = {CNT_W{1'b0}};
            idx_d     = {IDX_W{1'b0}};
            case (state_q)
                S_WAIT, S_DONE: begin
                    state_d = S_START;
                end
                S_START, S_RUN: begin
                    // Frame not finished in time: abandon it and restart layering
                    state_d   = S_START;
                    overrun_d = 1'b1;
                end
                default: begin
                    state_d = S_WAIT;
                end
            endcase
        end else begin
            case (state_q)
                S_WAIT: begin
                    state_d = S_WAIT;
                end
                S_START: begin
                    idle_d  = {CNT_W{1'b0}};
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (cur_req_s) begin
                        wr_en_s     = 1'b1;
                        idle_d      = {CNT_W{1'b0}};
                        phase_end_s = cur_last_s;
                    end else if (idle_q == CNT_MAX) begin
                        skipped_d[idx_q] = 1'b1;
                        phase_end_s      = 1'b1;
                    end else begin
                        // Cannot pass CNT_MAX: that value ends the phase above
                        idle_d = idle_q + CNT_W'(1);
                    end
                    if (phase_end_s) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_START;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_WAIT;
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Buffer parity flips with every swap, matching the RAM's own toggle
    always_comb begin
        if (swap_now_s) begin
            back_buf_d = ~back_buf_q;
        end else begin
            back_buf_d = back_buf_q;
        end
    end

    // Grant and phase-start strobes; both are suppressed in the swap cycle
    always_comb begin
        gnt_s         = {NUM_REQ{1'b0}};
        phase_start_s = {NUM_REQ{1'b0}};
        if (swap_now_s) begin
            gnt_s         = {NUM_REQ{1'b0}};
            phase_start_s = {NUM_REQ{1'b0}};
        end else if (state_q == S_RUN) begin
            gnt_s[idx_q] = 1'b1;
        end else if (state_q == S_START) begin
            phase_start_s[idx_q] = 1'b1;
        end else begin
            gnt_s         = {NUM_REQ{1'b0}};
            phase_start_s = {NUM_REQ{1'b0}};
        end
    end

    // Sequencer state, phase index, idle counter and frame status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            idx_q      <= {IDX_W{1'b0}};
            idle_q     <= {CNT_W{1'b0}};
            skipped_q  <= {NUM_REQ{1'b0}};
            overrun_q  <= 1'b0;
            back_buf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            idle_q     <= idle_d;
            skipped_q  <= skipped_d;
            overrun_q  <= overrun_d;
            back_buf_q <= back_buf_d;
        end
    end

    vram_wr_mux #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .IDLE_ADDR (IDLE_A)
    ) u_wr_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en_s),
        .sel_i      (idx_q),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .addr_o     (addr_write),
        .data_o     (data_write)
    );

    assign gnt         = gnt_s;
    assign phase_start = phase_start_s;
    assign frame_done  = (state_q == S_DONE);
    assign overrun     = overrun_q;
    assign skipped     = skipped_q;
    assign back_buf    = back_buf_q;

endmodule
